// File: rtl/vpu_pkg.sv
// Shared scheduler types and parameter defaults for the VPU request path.
package vpu_pkg;

    localparam int DEF_REQ_CNT     = 4;
    localparam int DEF_INSTR_WIDTH = 64;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/vpu_rr_arbiter.sv
// Combinational round-robin pick: searches upward from rr_ptr with wrap-around.
module vpu_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(rr_ptr) + i) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vpu_req_scheduler.sv
// Shares one VPU between REQ_CNT requesters: round-robin grant, single
// outstanding request, completion or timeout reported back to the owner.
//
//  state        | meaning
//  SCHED_IDLE   | no request outstanding; grant when any requester is valid
//  SCHED_ISSUE  | presenting the latched request to the VPU until accepted
//  SCHED_WAIT   | request accepted; waiting for vpu_done_i or timeout
module vpu_req_scheduler
    import vpu_pkg::*;
#(
    parameter int REQ_CNT     = DEF_REQ_CNT,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [REQ_CNT-1:0]                  req_valid_i,
    input  logic [REQ_CNT-1:0][INSTR_WIDTH-1:0] req_instr_i,
    output logic [REQ_CNT-1:0]                  req_ready_o,
    output logic [REQ_CNT-1:0]                  req_done_o,
    output logic                                req_err_o,
    output logic                                vpu_valid_o,
    input  logic                                vpu_ready_i,
    output logic [INSTR_WIDTH-1:0]              vpu_instr_o,
    input  logic                                vpu_done_i,
    output logic                                busy_o,
    output logic [$clog2(REQ_CNT)-1:0]          owner_o
);

    localparam int IDX_W = $clog2(REQ_CNT);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    sched_state_t           state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [REQ_CNT-1:0]     done_q, done_d;
    logic                   err_q, err_d;

    logic [REQ_CNT-1:0]     arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;
    logic                   can_grant;

    vpu_rr_arbiter #(
        .N     (REQ_CNT),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req_valid_i),
        .rr_ptr    (rr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // The done pulse cycle is a forced bubble; rst_n gating keeps the accept
    // pulse quiet while reset is held.
    assign can_grant = rst_n && (state_q == SCHED_IDLE) && !(|done_q) && arb_any;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        done_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            SCHED_IDLE: begin
                if (can_grant) begin
                    instr_d = req_instr_i[arb_idx];
                    owner_d = arb_idx;
                    rr_d    = (arb_idx == IDX_W'(REQ_CNT - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = SCHED_ISSUE;
                end
            end
            SCHED_ISSUE: begin
                if (vpu_ready_i) begin
                    cnt_d   = '0;
                    state_d = SCHED_WAIT;
                end
            end
            SCHED_WAIT: begin
                // A completion on the terminal cycle wins over the timeout.
                if (vpu_done_i || (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
                    done_d  = REQ_CNT'(1) << owner_q;
                    err_d   = !vpu_done_i;
                    owner_d = '0;
                    state_d = SCHED_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCHED_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = can_grant ? arb_grant : '0;
    assign req_done_o  = done_q;
    assign req_err_o   = err_q;
    assign vpu_valid_o = (state_q == SCHED_ISSUE);
    assign vpu_instr_o = instr_q;
    assign busy_o      = (state_q != SCHED_IDLE);
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_vpu_req_scheduler.sv
// Directed bench for vpu_req_scheduler: grant order, backpressure, timeout,
// completion corner cases and mid-operation reset.
module tb_vpu_req_scheduler;

    localparam int RC = 4;
    localparam int IW = 64;
    localparam int TO = 16;

    logic                   clk;
    logic                   rst_n;
    logic [RC-1:0]          req_valid_i;
    logic [RC-1:0][IW-1:0]  req_instr_i;
    logic [RC-1:0]          req_ready_o;
    logic [RC-1:0]          req_done_o;
    logic                   req_err_o;
    logic                   vpu_valid_o;
    logic                   vpu_ready_i;
    logic [IW-1:0]          vpu_instr_o;
    logic                   vpu_done_i;
    logic                   busy_o;
    logic [1:0]             owner_o;

    int vec  = 0;
    int errs = 0;

    vpu_req_scheduler #(
        .REQ_CNT     (RC),
        .INSTR_WIDTH (IW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_instr_i (req_instr_i),
        .req_ready_o (req_ready_o),
        .req_done_o  (req_done_o),
        .req_err_o   (req_err_o),
        .vpu_valid_o (vpu_valid_o),
        .vpu_ready_i (vpu_ready_i),
        .vpu_instr_o (vpu_instr_o),
        .vpu_done_i  (vpu_done_i),
        .busy_o      (busy_o),
        .owner_o     (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready_o), 0);
        chk({tag, "_done"},  64'(req_done_o),  0);
        chk({tag, "_err"},   64'(req_err_o),   0);
        chk({tag, "_vval"},  64'(vpu_valid_o), 0);
        chk({tag, "_instr"}, vpu_instr_o,      0);
        chk({tag, "_busy"},  64'(busy_o),      0);
        chk({tag, "_owner"}, 64'(owner_o),     0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid_i = '0;
        vpu_ready_i = 1'b0;
        vpu_done_i  = 1'b0;
        for (int i = 0; i < RC; i++) req_instr_i[i] = 64'hA000 + 64'(i);

        // reset state, including no accept while reset is held
        step();
        req_valid_i = 4'b0100;
        #1;
        chk_all_zero("reset");
        req_valid_i = 4'b1111;
        rst_n = 1'b1;
        #1;

        // fairness: all valid -> 0,1,2,3,0 with a bubble on each done pulse
        for (int k = 0; k < 5; k++) begin
            chk("rr_ready", 64'(req_ready_o), 64'(4'b0001 << (k % 4)));
            step();
            chk("rr_vvalid", 64'(vpu_valid_o), 1);
            chk("rr_owner", 64'(owner_o), 64'(k % 4));
            chk("rr_instr", vpu_instr_o, 64'hA000 + 64'(k % 4));
            vpu_ready_i = 1'b1;
            step();
            vpu_ready_i = 1'b0;
            chk("rr_wait_vvalid", 64'(vpu_valid_o), 0);
            vpu_done_i = 1'b1;
            step();
            vpu_done_i = 1'b0;
            chk("rr_done", 64'(req_done_o), 64'(4'b0001 << (k % 4)));
            chk("rr_bubble", 64'(req_ready_o), 0);
            step();
        end
        req_valid_i = '0;

        // single request from requester 2
        req_instr_i[2] = 64'h0123_4567_89AB_CDEF;
        req_valid_i = 4'b0100;
        #1;
        chk("single_ready", 64'(req_ready_o), 64'h4);
        step();
        req_valid_i = '0;
        chk("single_ready_pulse", 64'(req_ready_o), 0);
        chk("single_vvalid", 64'(vpu_valid_o), 1);
        chk("single_instr", vpu_instr_o, 64'h0123_4567_89AB_CDEF);
        chk("single_owner", 64'(owner_o), 2);
        vpu_ready_i = 1'b1;
        step();
        vpu_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("single_nodone", 64'(req_done_o), 0);
            step();
        end
        vpu_done_i = 1'b1;
        step();
        vpu_done_i = 1'b0;
        chk("single_done", 64'(req_done_o), 64'h4);
        chk("single_err", 64'(req_err_o), 0);
        chk("single_idle", 64'(busy_o), 0);
        step();
        chk("single_done_pulse", 64'(req_done_o), 0);
        chk("single_owner_idle", 64'(owner_o), 0);

        // backpressure: ready low for 7 cycles, instr held while input changes
        req_instr_i[3] = 64'hB00B_0003;
        req_valid_i = 4'b1000;
        #1;
        chk("bp_ready", 64'(req_ready_o), 64'h8);
        step();
        req_valid_i = '0;
        for (int i = 0; i < 7; i++) begin
            chk("bp_vvalid", 64'(vpu_valid_o), 1);
            chk("bp_instr", vpu_instr_o, 64'hB00B_0003);
            req_instr_i[3] = 64'hDEAD_0000 + 64'(i);
            step();
        end
        chk("bp_vvalid_last", 64'(vpu_valid_o), 1);
        vpu_ready_i = 1'b1;
        step();
        vpu_ready_i = 1'b0;
        chk("bp_wait_vvalid", 64'(vpu_valid_o), 0);
        chk("bp_wait_busy", 64'(busy_o), 1);
        vpu_done_i = 1'b1;
        step();
        vpu_done_i = 1'b0;
        chk("bp_done", 64'(req_done_o), 64'h8);
        step();

        // timeout: rr_ptr is 0 so requester 1 wins; err 16 cycles into WAIT
        req_valid_i = 4'b0010;
        #1;
        chk("to_ready", 64'(req_ready_o), 64'h2);
        step();
        req_valid_i = '0;
        vpu_ready_i = 1'b1;
        step();
        vpu_ready_i = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("to_nodone", 64'(req_done_o), 0);
        end
        step();
        chk("to_done", 64'(req_done_o), 64'h2);
        chk("to_err", 64'(req_err_o), 1);
        chk("to_idle", 64'(busy_o), 0);
        step();
        chk("to_done_pulse", 64'(req_done_o), 0);
        chk("to_err_pulse", 64'(req_err_o), 0);

        // done on the terminal timeout cycle counts as normal completion
        req_valid_i = 4'b0100;
        #1;
        chk("last_ready", 64'(req_ready_o), 64'h4);
        step();
        req_valid_i = '0;
        vpu_ready_i = 1'b1;
        step();
        vpu_ready_i = 1'b0;
        for (int i = 1; i <= 15; i++) step();
        chk("last_nodone", 64'(req_done_o), 0);
        vpu_done_i = 1'b1;
        step();
        vpu_done_i = 1'b0;
        chk("last_done", 64'(req_done_o), 64'h4);
        chk("last_err", 64'(req_err_o), 0);
        step();

        // stray done in IDLE
        vpu_done_i = 1'b1;
        step();
        vpu_done_i = 1'b0;
        chk("stray_done", 64'(req_done_o), 0);
        chk("stray_busy", 64'(busy_o), 0);
        step();
        chk("stray_done2", 64'(req_done_o), 0);

        // reset in WAIT: rr_ptr is 3, so requester 3 is granted first
        req_valid_i = 4'b1000;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'h8);
        step();
        req_valid_i = '0;
        vpu_ready_i = 1'b1;
        step();
        vpu_ready_i = 1'b0;
        step();
        step();
        chk("rst_busy_before", 64'(busy_o), 1);
        #1;
        rst_n = 1'b0;
        req_valid_i = 4'b1111;
        #1;
        chk_all_zero("rst_wait");
        rst_n = 1'b1;
        #1;
        chk("rst_next_grant", 64'(req_ready_o), 64'h1);
        step();
        chk("rst_no_done", 64'(req_done_o), 0);
        chk("rst_owner", 64'(owner_o), 0);
        chk("rst_vvalid", 64'(vpu_valid_o), 1);
        req_valid_i = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/vpu_req_scheduler.md
VPU_REQ_SCHEDULER -- requirements
Module: vpu_req_scheduler

Interface
REQ-001 SHALL have parameter REQ_CNT, default 4: number of requesters sharing one VPU (2..8).
REQ-002 SHALL have parameter INSTR_WIDTH, default 64: width of one packed VPU request (opcode, func, src/dst addresses, delay).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: maximum cycles to wait for VPU completion.
REQ-004 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid_i  input  REQ_CNT  per-requester request valid.
REQ-007 SHALL have port req_instr_i  input  REQ_CNT x INSTR_WIDTH  per-requester packed request.
REQ-008 SHALL have port req_ready_o  output  REQ_CNT  one-hot accept pulse to the granted requester.
REQ-009 SHALL have port req_done_o  output  REQ_CNT  one-hot completion pulse to the owning requester.
REQ-010 SHALL have port req_err_o  output  1  qualifies req_done_o; 1 means the request timed out.
REQ-011 SHALL have port vpu_valid_o  output  1  request valid toward the VPU request interface.
REQ-012 SHALL have port vpu_ready_i  input  1  VPU accepts the request.
REQ-013 SHALL have port vpu_instr_o  output  INSTR_WIDTH  registered request toward the VPU.
REQ-014 SHALL have port vpu_done_i  input  1  single-cycle VPU write-back-complete pulse.
REQ-015 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-016 SHALL have port owner_o  output  clog2(REQ_CNT)  index of the current owner; 0 when idle.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE; only one request is outstanding at the VPU at any time.
REQ-018 In IDLE with any req_valid_i set, SHALL grant round-robin starting at rr_ptr and search upward with wrap-around.
REQ-019 On grant, SHALL pulse req_ready_o[g] combinationally for that cycle, latch req_instr_i[g] into vpu_instr_o and g into owner_o, set rr_ptr to (g+1) mod REQ_CNT, and move to ISSUE.
REQ-020 In ISSUE, SHALL hold vpu_valid_o=1 with a stable vpu_instr_o until vpu_ready_i=1, then move to WAIT_DONE with the timeout counter cleared.
REQ-021 In WAIT_DONE, SHALL increment the timeout counter each cycle while vpu_done_i=0.
REQ-022 In WAIT_DONE, on vpu_done_i=1, SHALL pulse req_done_o[owner] with req_err_o=0 on the next cycle (registered) and move to IDLE.
REQ-023 In WAIT_DONE, when the counter reaches TIMEOUT_CYC-1 without vpu_done_i, SHALL pulse req_done_o[owner] with req_err_o=1 on the next cycle and move to IDLE.
REQ-024 If vpu_done_i and the timeout condition occur in the same cycle, SHALL treat the completion as normal (req_err_o=0).
REQ-025 SHALL ignore vpu_done_i in IDLE and ISSUE.
REQ-026 SHALL ignore requests arriving in ISSUE or WAIT_DONE; requesters hold req_valid_i until req_ready_o.
REQ-027 SHALL make no grant in the cycle req_done_o pulses; the earliest next grant is the following cycle (one idle bubble).
REQ-028 The timeout counter SHALL be clog2(TIMEOUT_CYC) bits wide and SHALL NOT wrap.

Reset
REQ-029 On rst_n=0, SHALL asynchronously force state=IDLE, rr_ptr=0, counter=0, owner_o=0, vpu_instr_o=0, and vpu_valid_o, req_ready_o, req_done_o, req_err_o, busy_o all 0.
REQ-030 Reset mid-operation SHALL abandon the outstanding request with no done pulse.

Structure
REQ-031 The state enum (SCHED_IDLE, SCHED_ISSUE, SCHED_WAIT) and the defaults for REQ_CNT and TIMEOUT_CYC SHALL live in VPU_PKG.
REQ-032 Round-robin selection SHALL be a combinational sub-module vpu_rr_arbiter with inputs (req, rr_ptr) and outputs (grant one-hot, grant_idx, any).

Verification
REQ-033 Single request: req_valid_i=4'b0100 -> req_ready_o=4'b0100 for 1 cycle; vpu_valid_o next cycle; done 5 cycles after accept -> req_done_o=4'b0100 one cycle later with err=0.
REQ-034 Fairness: all four requesters held valid continuously -> grant order 0,1,2,3,0, with one IDLE bubble between requests.
REQ-035 Backpressure: vpu_ready_i low for 7 cycles -> vpu_valid_o and vpu_instr_o stay stable; WAIT_DONE is entered on the cycle after ready.
REQ-036 Timeout: TIMEOUT_CYC=16 and no vpu_done_i -> req_done_o[owner] with req_err_o=1 exactly 16 cycles after entering WAIT_DONE.
REQ-037 Corner cases:
- done on the last timeout cycle -> err=0.
- stray vpu_done_i in IDLE -> no req_done_o.
- rst_n low in WAIT_DONE -> all outputs 0 immediately, and the next grant starts from requester 0.
